// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Hazard and operand-forwarding controller for the 5-stage pipeline.
//   It keeps a shadow copy of destination-register state for the E, M and W
//   stages and derives from it the execute-stage forwarding selects, the
//   decode-stage branch-compare forwards, load-use and branch stalls, and a
//   HI/LO busy interlock for the multi-cycle mult/div unit.
//
//   Handshake note: there is no valid/ready pair here. The decode instruction
//   is "accepted" in any cycle where stall is low; while stall is high the
//   IF/ID register and PC hold (stall_f/stall_d) and E receives a bubble
//   (flush_e), so the same decode inputs are presented again next cycle.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   rs_d, rt_d          decode-stage source registers
//   uses_rs_d/uses_rt_d decode instruction actually reads rs/rt
//   write_reg_d         decode-stage destination register
//   reg_write_d         decode instruction writes the register file
//   mem_to_reg_d        decode instruction is a load
//   branch_d            decode instruction compares rs/rt in decode
//   muldiv_start_d      decode instruction issues mult/div
//   reads_hilo_d        decode instruction is mfhi/mflo
//   forward_a_e/_b_e    E operand selects: 00 regfile, 01 result_w, 10 alu_out_m
//   forward_a_d/_b_d    branch comparator operand takes alu_out_m
//   stall_f, stall_d    hold PC / IF/ID
//   flush_e             insert bubble into ID/EX
module hazard_forward_ctrl #(
  parameter int REG_BITS       = 5,
  parameter int MULDIV_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_BITS-1:0] rs_d,
  input  logic [REG_BITS-1:0] rt_d,
  input  logic                uses_rs_d,
  input  logic                uses_rt_d,
  input  logic [REG_BITS-1:0] write_reg_d,
  input  logic                reg_write_d,
  input  logic                mem_to_reg_d,
  input  logic                branch_d,
  input  logic                muldiv_start_d,
  input  logic                reads_hilo_d,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  output logic                forward_a_d,
  output logic                forward_b_d,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_e
);

  localparam logic [3:0] MD_LAT = 4'(MULDIV_LATENCY);

  // Shadow pipeline state
  logic [REG_BITS-1:0] write_reg_e, write_reg_m, write_reg_w;
  logic                reg_write_e, reg_write_m, reg_write_w;
  logic                mem_to_reg_e, mem_to_reg_m, mem_to_reg_w;
  logic [REG_BITS-1:0] rs_e, rt_e;
  logic                uses_rs_e, uses_rt_e;
  logic [3:0]          md_cnt;

  // The E-stage use flags and the W load flag are kept for observation by
  // checkers; no output depends on them.
  logic unused_shadow;
  assign unused_shadow = ^{uses_rs_e, uses_rt_e, mem_to_reg_w};

  logic match_e_rs, match_e_rt, load_m_rs, load_m_rt;
  logic lw_stall, br_stall, md_stall, stall;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_a_d, fwd_b_d;

  always_comb begin
    match_e_rs = uses_rs_d && reg_write_e && (write_reg_e != '0) && (write_reg_e == rs_d);
    match_e_rt = uses_rt_d && reg_write_e && (write_reg_e != '0) && (write_reg_e == rt_d);
    // A load in M still has no data for a decode-stage compare.
    load_m_rs  = uses_rs_d && mem_to_reg_m && (write_reg_m != '0) && (write_reg_m == rs_d);
    load_m_rt  = uses_rt_d && mem_to_reg_m && (write_reg_m != '0) && (write_reg_m == rt_d);

    lw_stall = mem_to_reg_e && (match_e_rs || match_e_rt);
    br_stall = branch_d && (match_e_rs || match_e_rt || load_m_rs || load_m_rt);
    md_stall = (md_cnt != 4'd0) && (reads_hilo_d || muldiv_start_d);
    stall    = lw_stall || br_stall || md_stall;

    // Selects come from registered state only; M wins over W.
    fwd_a = 2'b00;
    if (reg_write_m && (write_reg_m != '0) && (write_reg_m == rs_e))
      fwd_a = 2'b10;
    else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == rs_e))
      fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (reg_write_m && (write_reg_m != '0) && (write_reg_m == rt_e))
      fwd_b = 2'b10;
    else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == rt_e))
      fwd_b = 2'b01;

    fwd_a_d = branch_d && reg_write_m && (write_reg_m != '0) && (write_reg_m == rs_d);
    fwd_b_d = branch_d && reg_write_m && (write_reg_m != '0) && (write_reg_m == rt_d);
  end

  // Outputs are held at zero for the whole time reset is asserted.
  always_comb begin
    forward_a_e = rst_n ? fwd_a : 2'b00;
    forward_b_e = rst_n ? fwd_b : 2'b00;
    forward_a_d = rst_n && fwd_a_d;
    forward_b_d = rst_n && fwd_b_d;
    stall_f     = rst_n && stall;
    stall_d     = rst_n && stall;
    flush_e     = rst_n && stall;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_reg_e  <= '0;
      write_reg_m  <= '0;
      write_reg_w  <= '0;
      reg_write_e  <= 1'b0;
      reg_write_m  <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_to_reg_w <= 1'b0;
      rs_e         <= '0;
      rt_e         <= '0;
      uses_rs_e    <= 1'b0;
      uses_rt_e    <= 1'b0;
      md_cnt       <= 4'd0;
    end else begin
      write_reg_w  <= write_reg_m;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      write_reg_m  <= write_reg_e;
      reg_write_m  <= reg_write_e;
      mem_to_reg_m <= mem_to_reg_e;
      if (stall) begin
        write_reg_e  <= '0;
        reg_write_e  <= 1'b0;
        mem_to_reg_e <= 1'b0;
        rs_e         <= '0;
        rt_e         <= '0;
        uses_rs_e    <= 1'b0;
        uses_rt_e    <= 1'b0;
      end else begin
        write_reg_e  <= write_reg_d;
        reg_write_e  <= reg_write_d;
        mem_to_reg_e <= mem_to_reg_d;
        rs_e         <= rs_d;
        rt_e         <= rt_d;
        uses_rs_e    <= uses_rs_d;
        uses_rt_e    <= uses_rt_d;
      end
      // A start held behind a busy unit only reloads once it is accepted.
      if (muldiv_start_d && !stall)
        md_cnt <= MD_LAT;
      else if (md_cnt != 4'd0)
        md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Testbench for hazard_forward_ctrl: a directed per-cycle vector table for the
// pipeline corner cases, then random decode streams checked against an
// instruction-level pipeline model.
module tb_hazard_forward_ctrl;

  localparam int LAT = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] wr;
    logic       rw;
    logic       m2r;
    logic       br;
    logic       mds;
    logic       rhl;
  } instr_t;

  typedef struct {
    logic       rst;
    instr_t     ins;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fad;
    logic       fbd;
    logic       st;
    logic [3:0] md;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs_d, rt_d, write_reg_d;
  logic uses_rs_d, uses_rt_d, reg_write_d, mem_to_reg_d, branch_d;
  logic muldiv_start_d, reads_hilo_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic forward_a_d, forward_b_d, stall_f, stall_d, flush_e;

  hazard_forward_ctrl #(.REG_BITS(5), .MULDIV_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .write_reg_d(write_reg_d), .reg_write_d(reg_write_d),
    .mem_to_reg_d(mem_to_reg_d), .branch_d(branch_d),
    .muldiv_start_d(muldiv_start_d), .reads_hilo_d(reads_hilo_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e)
  );

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  // instruction builders
  function automatic instr_t i_alu(input int rd, input int rs, input int rt);
    instr_t i = '0;
    i.rs = 5'(rs); i.rt = 5'(rt); i.urs = 1'b1; i.urt = 1'b1;
    i.wr = 5'(rd); i.rw = 1'b1;
    return i;
  endfunction
  function automatic instr_t i_imm(input int rd, input int rs);
    instr_t i = '0;
    i.rs = 5'(rs); i.urs = 1'b1; i.wr = 5'(rd); i.rw = 1'b1;
    return i;
  endfunction
  function automatic instr_t i_lw(input int rd, input int rs);
    instr_t i = i_imm(rd, rs);
    i.m2r = 1'b1;
    return i;
  endfunction
  function automatic instr_t i_beq(input int rs, input int rt);
    instr_t i = '0;
    i.rs = 5'(rs); i.rt = 5'(rt); i.urs = 1'b1; i.urt = 1'b1; i.br = 1'b1;
    return i;
  endfunction
  function automatic instr_t i_mult(input int rs, input int rt);
    instr_t i = '0;
    i.rs = 5'(rs); i.rt = 5'(rt); i.urs = 1'b1; i.urt = 1'b1; i.mds = 1'b1;
    return i;
  endfunction
  function automatic instr_t i_mfhi(input int rd);
    instr_t i = '0;
    i.wr = 5'(rd); i.rw = 1'b1; i.rhl = 1'b1;
    return i;
  endfunction

  task automatic v(input logic rst, input instr_t ins, input logic [1:0] fa,
                   input logic [1:0] fb, input logic fad, input logic fbd,
                   input logic st, input logic [3:0] md);
    vec_t x;
    x.rst = rst; x.ins = ins; x.fa = fa; x.fb = fb;
    x.fad = fad; x.fbd = fbd; x.st = st; x.md = md;
    vecs.push_back(x);
  endtask

  // driver
  task automatic drive(input instr_t ins, input logic rst);
    rst_n = rst;
    rs_d = ins.rs; rt_d = ins.rt; uses_rs_d = ins.urs; uses_rt_d = ins.urt;
    write_reg_d = ins.wr; reg_write_d = ins.rw; mem_to_reg_d = ins.m2r;
    branch_d = ins.br; muldiv_start_d = ins.mds; reads_hilo_d = ins.rhl;
  endtask

  // scoreboard compare
  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [1:0] fa,
                         input logic [1:0] fb, input logic fad, input logic fbd,
                         input logic st, input logic [3:0] md);
    chk({tag, ".forward_a_e"}, idx, int'(forward_a_e), int'(fa));
    chk({tag, ".forward_b_e"}, idx, int'(forward_b_e), int'(fb));
    chk({tag, ".forward_a_d"}, idx, int'(forward_a_d), int'(fad));
    chk({tag, ".forward_b_d"}, idx, int'(forward_b_d), int'(fbd));
    chk({tag, ".stall"}, idx, int'({stall_f, stall_d, flush_e}), st ? 7 : 0);
    chk({tag, ".md_cnt"}, idx, int'(dut.md_cnt), int'(md));
  endtask

  // reference model: instructions occupying E/M/W, mult/div by issue cycle
  instr_t m_e, m_m, m_w;
  int  cyc;
  int  issue_cyc;
  bit  have_issue;

  function automatic bit writes(input instr_t p, input logic [4:0] r, input bit used);
    return used && p.rw && p.wr != 0 && p.wr == r;
  endfunction
  function automatic bit loads(input instr_t p, input logic [4:0] r, input bit used);
    return used && p.m2r && p.wr != 0 && p.wr == r;
  endfunction
  function automatic logic [1:0] src_sel(input logic [4:0] r);
    if (writes(m_m, r, 1'b1)) return 2'b10;
    if (writes(m_w, r, 1'b1)) return 2'b01;
    return 2'b00;
  endfunction
  function automatic int md_left();
    int age = cyc - issue_cyc;
    if (have_issue && age >= 1 && age <= LAT) return LAT - age + 1;
    return 0;
  endfunction
  function automatic bit model_stall(input instr_t d);
    bit dep_e, ld;
    dep_e = writes(m_e, d.rs, d.urs) || writes(m_e, d.rt, d.urt);
    ld    = loads(m_m, d.rs, d.urs) || loads(m_m, d.rt, d.urt);
    return (m_e.m2r && dep_e) || (d.br && (dep_e || ld)) ||
           (md_left() != 0 && (d.mds || d.rhl));
  endfunction

  function automatic instr_t rand_instr();
    instr_t i = '0;
    i.rs  = 5'($urandom_range(0, 3));
    i.rt  = 5'($urandom_range(0, 3));
    i.urs = 1'($urandom_range(0, 1));
    i.urt = 1'($urandom_range(0, 1));
    i.wr  = 5'($urandom_range(0, 3));
    i.rw  = 1'($urandom_range(0, 1));
    i.m2r = i.rw && ($urandom_range(0, 2) == 0);
    i.br  = ($urandom_range(0, 3) == 0);
    i.mds = ($urandom_range(0, 5) == 0);
    i.rhl = ($urandom_range(0, 5) == 0);
    return i;
  endfunction

  initial begin
    instr_t nop = '0;
    instr_t cur;
    logic   rst_now;
    bit     st_exp;

    drive(nop, 1'b0);
    repeat (2) @(posedge clk);

    // reset rows: outputs forced low even with hazards on the inputs
    v(0, i_beq(2, 2), 0, 0, 0, 0, 0, 0);
    v(0, i_mult(1, 2), 0, 0, 0, 0, 0, 0);
    // M->E forward, then W->E forward with one independent instr between
    v(1, i_alu(3, 1, 2), 0, 0, 0, 0, 0, 0);
    v(1, i_alu(5, 3, 4), 0, 0, 0, 0, 0, 0);
    v(1, nop,            2, 0, 0, 0, 0, 0);
    v(1, i_alu(3, 1, 2), 0, 0, 0, 0, 0, 0);
    v(1, i_imm(7, 1),    0, 0, 0, 0, 0, 0);
    v(1, i_alu(5, 3, 4), 0, 0, 0, 0, 0, 0);
    v(1, nop,            1, 0, 0, 0, 0, 0);
    // same register in M and W: M wins; r0 destinations never forward
    v(1, i_alu(3, 1, 2), 0, 0, 0, 0, 0, 0);
    v(1, i_imm(3, 1),    0, 0, 0, 0, 0, 0);
    v(1, i_alu(8, 6, 3), 0, 0, 0, 0, 0, 0);
    v(1, nop,            0, 2, 0, 0, 0, 0);
    v(1, i_alu(0, 1, 2), 0, 0, 0, 0, 0, 0);
    v(1, i_alu(0, 1, 2), 0, 0, 0, 0, 0, 0);
    v(1, i_alu(8, 6, 0), 0, 0, 0, 0, 0, 0);
    v(1, nop,            0, 0, 0, 0, 0, 0);
    // load-use: one stall cycle, then W forward
    v(1, i_lw(5, 1),     0, 0, 0, 0, 0, 0);
    v(1, i_alu(6, 5, 2), 0, 0, 0, 0, 1, 0);
    v(1, i_alu(6, 5, 2), 0, 0, 0, 0, 0, 0);
    v(1, nop,            1, 0, 0, 0, 0, 0);
    // branch behind ALU op: one stall, then decode forward
    v(1, i_alu(2, 1, 3), 0, 0, 0, 0, 0, 0);
    v(1, i_beq(2, 4),    0, 0, 0, 0, 1, 0);
    v(1, i_beq(2, 4),    0, 0, 1, 0, 0, 0);
    // branch behind load: two stalls
    v(1, i_lw(2, 1),     1, 0, 0, 0, 0, 0);
    v(1, i_beq(2, 4),    0, 0, 0, 0, 1, 0);
    v(1, i_beq(2, 4),    0, 0, 1, 0, 1, 0);
    v(1, i_beq(2, 4),    0, 0, 0, 0, 0, 0);
    v(1, nop,            0, 0, 0, 0, 0, 0);
    // mult then mfhi: four stalls with md_cnt 4,3,2,1
    v(1, i_mult(1, 2),   0, 0, 0, 0, 0, 0);
    v(1, i_mfhi(9),      0, 0, 0, 0, 1, 4);
    v(1, i_mfhi(9),      0, 0, 0, 0, 1, 3);
    v(1, i_mfhi(9),      0, 0, 0, 0, 1, 2);
    v(1, i_mfhi(9),      0, 0, 0, 0, 1, 1);
    v(1, i_mfhi(9),      0, 0, 0, 0, 0, 0);
    // back-to-back mults
    v(1, i_mult(1, 2),   0, 0, 0, 0, 0, 0);
    v(1, i_mult(1, 2),   0, 0, 0, 0, 1, 4);
    v(1, i_mult(1, 2),   0, 0, 0, 0, 1, 3);
    v(1, i_mult(1, 2),   0, 0, 0, 0, 1, 2);
    v(1, i_mult(1, 2),   0, 0, 0, 0, 1, 1);
    v(1, i_mult(1, 2),   0, 0, 0, 0, 0, 0);
    v(1, nop,            0, 0, 0, 0, 0, 4);
    // reset during a load-use stall
    v(1, i_lw(5, 1),     0, 0, 0, 0, 0, 3);
    v(0, i_alu(6, 5, 2), 0, 0, 0, 0, 0, 2);
    v(1, i_alu(6, 5, 2), 0, 0, 0, 0, 0, 0);
    v(1, nop,            0, 0, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].ins, vecs[k].rst);
      #1;
      chk_all("vec", k, vecs[k].fa, vecs[k].fb, vecs[k].fad, vecs[k].fbd,
              vecs[k].st, vecs[k].md);
    end

    // random phase
    @(negedge clk);
    drive(nop, 1'b0);
    m_e = '0; m_m = '0; m_w = '0;
    cyc = 0; issue_cyc = 0; have_issue = 0;
    cur = nop;
    st_exp = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_now = ($urandom_range(0, 99) != 0);
      if (!st_exp) cur = rand_instr();
      drive(cur, rst_now);
      #1;
      st_exp = rst_now && model_stall(cur);
      if (rst_now)
        chk_all("rnd", n, src_sel(m_e.rs), src_sel(m_e.rt),
                cur.br && writes(m_m, cur.rs, 1'b1),
                cur.br && writes(m_m, cur.rt, 1'b1),
                st_exp, 4'(md_left()));
      else
        chk_all("rnd_rst", n, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'(md_left()));
      // advance the model across the coming rising edge
      if (!rst_now) begin
        m_e = '0; m_m = '0; m_w = '0;
        have_issue = 0;
      end else begin
        m_w = m_m;
        m_m = m_e;
        m_e = st_exp ? nop : cur;
        if (cur.mds && !st_exp) begin
          have_issue = 1;
          issue_cyc  = cyc;
        end
      end
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline. It is the producer side of the execute-stage operand-forwarding selects consumed by the A/B forwarding muxes.
- Keeps its own shadow copy of destination-register state for the E, M and W stages, advanced every clock.
- Generates the 2-bit forward selects, decode-stage branch-compare forwards, load-use and branch stalls, and a multi-cycle HI/LO busy interlock for the mult/div unit.

Parameters:
- REG_BITS, 5, register-address width.
- MULDIV_LATENCY, 4, cycles from mult/div issue until HI/LO is readable. Valid range is 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- rs_d  in  REG_BITS  decode-stage source A register.
- rt_d  in  REG_BITS  decode-stage source B register.
- uses_rs_d  in  1  decode instruction reads rs.
- uses_rt_d  in  1  decode instruction reads rt.
- write_reg_d  in  REG_BITS  decode-stage destination register.
- reg_write_d  in  1  decode instruction writes the register file.
- mem_to_reg_d  in  1  decode instruction is a load.
- branch_d  in  1  decode instruction compares rs/rt in decode.
- muldiv_start_d  in  1  decode instruction issues mult/div.
- reads_hilo_d  in  1  decode instruction is mfhi/mflo.
- forward_a_e  out  2  E operand A select: 00 regfile, 01 result_w, 10 alu_out_m.
- forward_b_e  out  2  E operand B select, same encoding as forward_a_e.
- forward_a_d  out  1  branch comparator A takes alu_out_m.
- forward_b_d  out  1  branch comparator B takes alu_out_m.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID register.
- flush_e  out  1  insert bubble into ID/EX.

Behaviour:
- Shadow state per stage X in {E, M, W}: write_reg_x, reg_write_x, mem_to_reg_x. Stage E additionally holds rs_e, rt_e, uses_rs_e, uses_rt_e.
- Each rising edge with rst_n=1: W<=M, M<=E.
  - If flush_e=1: E<=bubble (all fields 0).
  - Otherwise E<=decode inputs.
- rst_n=0 at an edge: all shadow state and the mult/div counter go to 0.
- While rst_n=0, all outputs are forced to 0. The first cycle after reset therefore shows forward_*=00 and all stalls 0.
- Operand A forwarding (forward_a_e), first match wins:
  - 10 if reg_write_m, write_reg_m!=0 and write_reg_m==rs_e.
  - else 01 if reg_write_w, write_reg_w!=0 and write_reg_w==rs_e.
  - else 00.
  - M has priority over W for the same register.
  - Register 0 is never forwarded.
  - The select is a function of registered state only, so it is glitch-free within the cycle.
- Operand B forwarding (forward_b_e): same rule as A, using rt_e.
- Decode forwarding: forward_a_d=1 iff branch_d, reg_write_m, write_reg_m!=0 and write_reg_m==rs_d. forward_b_d is the same using rt_d.
- "Match" terms for the stall conditions:
  - match_e(r) = reg_write_e && write_reg_e!=0 && write_reg_e==r.
  - Apply to rs_d only when uses_rs_d=1, and to rt_d only when uses_rt_d=1.
- Stall conditions:
  - lw_stall = mem_to_reg_e && match_e on rs_d or rt_d.
  - br_stall = branch_d && (match_e on rs_d/rt_d, or mem_to_reg_m && write_reg_m!=0 && write_reg_m matching rs_d/rt_d).
  - md_stall = (md_cnt!=0) && (reads_hilo_d || muldiv_start_d).
  - stall = lw_stall | br_stall | md_stall.
  - stall_f = stall_d = flush_e = stall.
- Mult/div counter md_cnt, 4 bits:
  - If muldiv_start_d && !stall: md_cnt<=MULDIV_LATENCY.
  - Else if md_cnt!=0: md_cnt<=md_cnt-1.
  - A start stalled behind a busy unit does not reload the counter until it is accepted.
  - HI/LO reads are released in the cycle md_cnt reads 0.
- Simultaneous hazards: the stall is held until every condition clears. Forwarding selects continue to update from shadow state during the stall, since the E stage holds bubbles.
- Reset mid-stall: the next cycle shows no stall, and md_cnt=0.

Test Plan:
- add r3 in E→M, followed by sub using rs=r3 → forward_a_e=10 in the cycle sub is in E. With one independent instruction in between, forward_a_e=01.
- add r3 and addi r3 in M and W simultaneously, consumer rt=r3 → forward_b_e=10 (M wins). With r0 as the destination in M and W → forward_b_e=00.
- lw r5 in E, decode add with rs=r5 → exactly one cycle of stall_f=stall_d=flush_e=1, then forward_a_e=01 when add reaches E.
- beq rs=r2 in decode with add r2 in E → one-cycle stall, then forward_a_d=1 when add reaches M. With lw r2 in E → two stall cycles.
- mult issued, then mfhi immediately following, MULDIV_LATENCY=4 → mfhi stalls for 4 cycles and md_cnt is observed 4,3,2,1 across them. mfhi is released when md_cnt=0. A second mult issued back-to-back also stalls 4 cycles.
- rst_n=0 asserted for one cycle during a load-use stall → outputs 0 immediately, shadow state cleared. After release, the same decode instruction proceeds without stalling.
